// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings
// and the width helper that sizes the shift amount and the pipeline depth.
package barrel_shifter_pkg;

    // Operation select carried alongside every transaction.
    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // log2 of a power-of-two operand width; also the number of pipeline stages.
    function automatic int log2w(input int width);
        int n;
        n = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < width) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake and data bus of the pipelined barrel shifter. The master side
// presents operands and accepts results; the slave side is the shifter.
interface pipelined_barrel_shifter_if
    import barrel_shifter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    localparam int LOG2W = log2w(DATA_WIDTH);

    // input side
    logic                  ivalid;
    logic                  iready;
    logic [DATA_WIDTH-1:0] idata;
    logic [LOG2W-1:0]      shamt;
    mode_e                 mode;

    // output side
    logic                  ovalid;
    logic                  oready;
    logic [DATA_WIDTH-1:0] odata;
    logic                  ocarry;

    modport master (
        output ivalid, idata, shamt, mode, oready,
        input  iready, ovalid, odata, ocarry
    );

    modport slave (
        input  ivalid, idata, shamt, mode, oready,
        output iready, ovalid, odata, ocarry
    );

endinterface

// File: rtl/pipelined_barrel_shifter_stage.sv
// One pipeline stage: conditionally shifts by 2^S under the carried mode and
// registers data, valid, mode, shift amount and carry. Stage 0 additionally
// derives the carry-out from the untouched operand.
module shifter_stage
    import barrel_shifter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int S          = 0,
    localparam int LOG2W     = log2w(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adv,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  mode_e                 in_mode,
    input  logic [LOG2W-1:0]      in_shamt,
    input  logic                  in_carry,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_data,
    output mode_e                 out_mode,
    output logic [LOG2W-1:0]      out_shamt,
    output logic                  out_carry
);
    localparam int SH = 1 << S;

    logic                  vld_d,   vld_q;
    logic [DATA_WIDTH-1:0] data_d,  data_q;
    mode_e                 mode_d,  mode_q;
    logic [LOG2W-1:0]      shamt_d, shamt_q;
    logic                  carry_d, carry_q;

    logic [DATA_WIDTH-1:0] shifted;
    logic                  carry_in;

    generate
        if (S == 0) begin : g_carry_calc
            logic [LOG2W-1:0] lsl_idx;
            logic [LOG2W-1:0] rsh_idx;
            logic             unused_carry;

            // DATA_WIDTH - shamt wraps to exactly the LSL carry index for shamt != 0
            assign lsl_idx      = LOG2W'(0) - in_shamt;
            assign rsh_idx      = in_shamt - LOG2W'(1);
            assign unused_carry = in_carry;

            // Carry is taken from the original operand, before any stage shifts it.
            always_comb begin
                carry_in = 1'b0;
                if (in_shamt != '0) begin
                    if (in_mode == MODE_LSL) begin
                        carry_in = in_data[lsl_idx];
                    end else begin
                        carry_in = in_data[rsh_idx];
                    end
                end
            end
        end else begin : g_carry_pass
            assign carry_in = in_carry;
        end
    endgenerate

    // Fixed shift by 2^S for each operation; rotates and arithmetic shifts
    // compose correctly across stages, so each stage only needs its own bit.
    always_comb begin
        shifted = in_data;
        case (in_mode)
            MODE_LSL: shifted = in_data << SH;
            MODE_LSR: shifted = in_data >> SH;
            MODE_ASR: shifted = $unsigned($signed(in_data) >>> SH);
            MODE_ROR: shifted = (in_data >> SH) | (in_data << (DATA_WIDTH - SH));
            default:  shifted = in_data;
        endcase
    end

    // Load from the predecessor when the pipe advances, otherwise hold.
    always_comb begin
        vld_d   = vld_q;
        data_d  = data_q;
        mode_d  = mode_q;
        shamt_d = shamt_q;
        carry_d = carry_q;
        if (adv) begin
            vld_d   = in_vld;
            data_d  = in_shamt[S] ? shifted : in_data;
            mode_d  = in_mode;
            shamt_d = in_shamt;
            carry_d = carry_in;
        end
    end

    // Stage registers; reset empties the stage and zeroes its payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= 1'b0;
            data_q  <= '0;
            mode_q  <= MODE_LSL;
            shamt_q <= '0;
            carry_q <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            shamt_q <= shamt_d;
            carry_q <= carry_d;
        end
    end

    assign out_vld   = vld_q;
    assign out_data  = data_q;
    assign out_mode  = mode_q;
    assign out_shamt = shamt_q;
    assign out_carry = carry_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: LOG2W register stages, stage s handling shift
// bit s. The whole pipe moves in lock-step, stalling only when a valid result
// sits at the output and the consumer is not ready.
module pipelined_barrel_shifter
    import barrel_shifter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input logic                      clk,
    input logic                      rst,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int LOG2W = log2w(DATA_WIDTH);

    // index 0 is the raw input, index s+1 is the output of stage s
    logic [LOG2W:0]                 vld_pipe;
    logic [LOG2W:0][DATA_WIDTH-1:0] data_pipe;
    mode_e                          mode_pipe [LOG2W+1];
    logic [LOG2W:0][LOG2W-1:0]      shamt_pipe;
    logic [LOG2W:0]                 carry_pipe;

    logic adv;
    logic unused_tail;

    // Advance whenever the output slot is empty or being consumed.
    assign adv        = bus.oready | ~vld_pipe[LOG2W];
    assign bus.iready = adv;

    assign vld_pipe[0]   = bus.ivalid;
    assign data_pipe[0]  = bus.idata;
    assign mode_pipe[0]  = bus.mode;
    assign shamt_pipe[0] = bus.shamt;
    assign carry_pipe[0] = 1'b0;

    for (genvar s = 0; s < LOG2W; s++) begin : g_stage
        shifter_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .S          (s)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .adv       (adv),
            .in_vld    (vld_pipe[s]),
            .in_data   (data_pipe[s]),
            .in_mode   (mode_pipe[s]),
            .in_shamt  (shamt_pipe[s]),
            .in_carry  (carry_pipe[s]),
            .out_vld   (vld_pipe[s+1]),
            .out_data  (data_pipe[s+1]),
            .out_mode  (mode_pipe[s+1]),
            .out_shamt (shamt_pipe[s+1]),
            .out_carry (carry_pipe[s+1])
        );
    end

    assign bus.ovalid = vld_pipe[LOG2W];
    assign bus.odata  = data_pipe[LOG2W];
    assign bus.ocarry = carry_pipe[LOG2W];

    // mode and shift amount are spent by the time they reach the output
    assign unused_tail = ^{shamt_pipe[LOG2W], mode_pipe[LOG2W]};

endmodule
